// File: rtl/imem_loader_if.sv
// Byte-stream intake and instruction-RAM write port of the instruction memory loader.
// Handshake: a byte moves on any rising CLK edge where ByteValid && ByteReady; ByteIn must be stable while ByteValid is high.
interface imem_loader_if;
   logic        Start;
   logic [7:0]  ByteIn;
   logic        ByteValid;
   logic        ByteReady;
   logic [63:0] WrAddr;
   logic [31:0] WrData;
   logic        WrEn;
   logic        CpuHold;
   logic        Done;
   logic        Error;
   logic [15:0] WordCount;

   modport master (
      output Start, ByteIn, ByteValid,
      input  ByteReady, WrAddr, WrData, WrEn, CpuHold, Done, Error, WordCount
   );

   modport slave (
      input  Start, ByteIn, ByteValid,
      output ByteReady, WrAddr, WrData, WrEn, CpuHold, Done, Error, WordCount
   );
endinterface

// File: rtl/imem_loader.sv
// Loads a length-prefixed, XOR-checksummed byte stream into instruction RAM as 32-bit words,
// holding the CPU for the duration of the load.
module imem_loader #(
   parameter logic [63:0] BASE_ADDR = 64'h0,
   parameter int          MAX_WORDS = 40
) (
   input  logic         CLK,
   input  logic         Reset_L,
   imem_loader_if.slave bus,
   output logic [2:0]   dbg_state
);

   typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, WRITE, CSUM, DONE, ERR} state_e;

   localparam logic [15:0] MAX_W = 16'(MAX_WORDS);

   state_e      state, state_nx;
   logic [15:0] len;
   logic [7:0]  csum;
   logic [1:0]  idx;
   logic [23:0] word_asm;
   logic [15:0] word_count;
   logic [63:0] wr_addr;
   logic [31:0] wr_data;
   logic        byte_ready, wr_en, cpu_hold, xfer;
   logic [15:0] len_full, count_inc;
   logic        len_bad;

   assign xfer      = bus.ByteValid && byte_ready;
   assign len_full  = {bus.ByteIn, len[7:0]};
   assign len_bad   = (len_full == 16'd0) || (len_full > MAX_W);
   assign count_inc = word_count + 16'd1;

   always_ff @(posedge CLK or negedge Reset_L) begin
      if (!Reset_L) state <= IDLE;
      else          state <= state_nx;
   end

   // Ready is a pure function of state, so the transfer qualifier never loops back through ByteValid.
   always_comb begin
      state_nx   = state;
      byte_ready = 1'b0;
      wr_en      = 1'b0;
      cpu_hold   = 1'b0;
      case (state)
         IDLE, DONE, ERR: if (bus.Start) state_nx = LEN0;
         LEN0: begin
            byte_ready = 1'b1;
            cpu_hold   = 1'b1;
            if (bus.ByteValid) state_nx = LEN1;
         end
         LEN1: begin
            byte_ready = 1'b1;
            cpu_hold   = 1'b1;
            if (bus.ByteValid) state_nx = len_bad ? ERR : DATA;
         end
         DATA: begin
            byte_ready = 1'b1;
            cpu_hold   = 1'b1;
            if (bus.ByteValid && idx == 2'd3) state_nx = WRITE;
         end
         WRITE: begin
            wr_en    = 1'b1;
            cpu_hold = 1'b1;
            state_nx = (count_inc == len) ? CSUM : DATA;
         end
         CSUM: begin
            byte_ready = 1'b1;
            cpu_hold   = 1'b1;
            if (bus.ByteValid) state_nx = (bus.ByteIn == csum) ? DONE : ERR;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge Reset_L) begin
      if (!Reset_L) begin
         len        <= '0;
         csum       <= '0;
         idx        <= '0;
         word_asm   <= '0;
         word_count <= '0;
         wr_addr    <= '0;
         wr_data    <= '0;
      end else begin
         if ((state == IDLE || state == DONE || state == ERR) && bus.Start) begin
            word_count <= '0;
            csum       <= '0;
            idx        <= '0;
         end
         if (xfer) begin
            case (state)
               LEN0: len[7:0]  <= bus.ByteIn;
               LEN1: len[15:8] <= bus.ByteIn;
               DATA: begin
                  csum <= csum ^ bus.ByteIn;
                  idx  <= idx + 2'd1;
                  case (idx)
                     2'd0: word_asm[7:0]   <= bus.ByteIn;
                     2'd1: word_asm[15:8]  <= bus.ByteIn;
                     2'd2: word_asm[23:16] <= bus.ByteIn;
                     default: begin
                        // Top lane goes straight to the write register so WRITE can follow immediately.
                        wr_data <= {bus.ByteIn, word_asm};
                        wr_addr <= BASE_ADDR + {46'd0, word_count, 2'b00};
                     end
                  endcase
               end
               default: ;
            endcase
         end
         if (state == WRITE) word_count <= count_inc;
      end
   end

   assign bus.ByteReady = byte_ready;
   assign bus.WrEn      = wr_en;
   assign bus.CpuHold   = cpu_hold;
   assign bus.WrAddr    = wr_addr;
   assign bus.WrData    = wr_data;
   assign bus.Done      = (state == DONE);
   assign bus.Error     = (state == ERR);
   assign bus.WordCount = word_count;
   assign dbg_state     = state;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: two instances (base 0x0 and 0x34) share one byte stream,
// and a stream-level model predicts every write and the final status.
module tb_imem_loader;

   localparam logic [63:0] BASE_A = 64'h0;
   localparam logic [63:0] BASE_B = 64'h34;
   localparam int          MAXW   = 40;

   logic CLK = 1'b0;
   logic Reset_L = 1'b0;
   logic [2:0] dbg_state_a, dbg_state_b;

   imem_loader_if if_a ();
   imem_loader_if if_b ();

   assign if_b.Start     = if_a.Start;
   assign if_b.ByteIn    = if_a.ByteIn;
   assign if_b.ByteValid = if_a.ByteValid;

   imem_loader #(.BASE_ADDR(BASE_A), .MAX_WORDS(MAXW)) u_dut_a (
      .CLK(CLK), .Reset_L(Reset_L), .bus(if_a.slave), .dbg_state(dbg_state_a));
   imem_loader #(.BASE_ADDR(BASE_B), .MAX_WORDS(MAXW)) u_dut_b (
      .CLK(CLK), .Reset_L(Reset_L), .bus(if_b.slave), .dbg_state(dbg_state_b));

   // ---------------- clock / reset ----------------
   always #5 CLK = ~CLK;

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_pass   = 0;
   logic [95:0] exp_a_q[$];
   logic [95:0] exp_b_q[$];
   logic [7:0]  stream_q[$];
   logic        exp_done, exp_err;
   logic [15:0] exp_wc;
   logic        lat_pending = 1'b0;

   task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   // Reference: parse the stream by its format rules.
   task automatic model();
      int n;
      logic [7:0]  x;
      logic [31:0] w;
      n = {stream_q[1], stream_q[0]};
      x = 8'h00;
      exp_done = 1'b0;
      exp_err  = 1'b0;
      exp_wc   = 16'd0;
      if (n == 0 || n > MAXW) begin
         exp_err = 1'b1;
      end else begin
         for (int k = 0; k < n; k++) begin
            w = 32'h0;
            for (int b = 0; b < 4; b++) begin
               w = w | (32'(stream_q[2 + 4*k + b]) << (8*b));
               x = x ^ stream_q[2 + 4*k + b];
            end
            exp_a_q.push_back({BASE_A + 64'(4*k), w});
            exp_b_q.push_back({BASE_B + 64'(4*k), w});
         end
         exp_wc = 16'(n);
         if (stream_q[2 + 4*n] == x) exp_done = 1'b1;
         else exp_err = 1'b1;
      end
   endtask

   always @(negedge CLK) begin
      if (Reset_L && if_a.WrEn) begin
         if (exp_a_q.size() == 0) check("wr_a_unexpected", 96'd1, 96'd0);
         else check("wr_a", {if_a.WrAddr, if_a.WrData}, exp_a_q.pop_front());
      end
      if (Reset_L && if_b.WrEn) begin
         if (exp_b_q.size() == 0) check("wr_b_unexpected", 96'd1, 96'd0);
         else check("wr_b", {if_b.WrAddr, if_b.WrData}, exp_b_q.pop_front());
      end
   end

   // ---------------- driver tasks ----------------
   task automatic start_load();
      @(negedge CLK);
      if_a.Start = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      if_a.Start = 1'b0;
      check("start_done",  {95'd0, if_a.Done},  96'd0);
      check("start_err",   {95'd0, if_a.Error}, 96'd0);
      check("start_wc_a",  {80'd0, if_a.WordCount}, 96'd0);
      check("start_wc_b",  {80'd0, if_b.WordCount}, 96'd0);
      check("start_hold",  {95'd0, if_a.CpuHold}, 96'd1);
   endtask

   task automatic send(input int valid_pct, input int start_at, input int stop_after);
      int i, cyc, n;
      logic rdy, pulsed, lenok;
      i = 0; cyc = 0; pulsed = 1'b0;
      n = {stream_q[1], stream_q[0]};
      lenok = (n != 0) && (n <= MAXW);
      while (i < stop_after && cyc < 2000) begin
         @(negedge CLK);
         if (lat_pending) check("wr_latency", {95'd0, if_a.WrEn}, 96'd1);
         lat_pending = 1'b0;
         if_a.ByteIn    = stream_q[i];
         if_a.ByteValid = ($urandom_range(99) < valid_pct);
         if_a.Start     = (i == start_at) && !pulsed;
         if (i == start_at) pulsed = 1'b1;
         rdy = if_a.ByteReady;
         @(posedge CLK);
         if (if_a.ByteValid && rdy) begin
            if (lenok && i >= 2 && i < 2 + 4*n && ((i - 2) % 4) == 3) lat_pending = 1'b1;
            i++;
         end
         cyc++;
      end
      if (cyc >= 2000) check("stream_timeout", 96'd0, 96'd1);
   endtask

   task automatic finish_stream();
      @(negedge CLK);
      if (lat_pending) check("wr_latency", {95'd0, if_a.WrEn}, 96'd1);
      lat_pending    = 1'b0;
      if_a.ByteValid = 1'b0;
      if_a.Start     = 1'b0;
   endtask

   task automatic wait_result(input string tag);
      int k;
      k = 0;
      while (!(if_a.Done || if_a.Error) && k < 20) begin
         @(negedge CLK);
         k++;
      end
      if (k >= 20) check({tag, "_timeout"}, 96'd0, 96'd1);
      check({tag, "_done_a"}, {95'd0, if_a.Done},  {95'd0, exp_done});
      check({tag, "_err_a"},  {95'd0, if_a.Error}, {95'd0, exp_err});
      check({tag, "_done_b"}, {95'd0, if_b.Done},  {95'd0, exp_done});
      check({tag, "_err_b"},  {95'd0, if_b.Error}, {95'd0, exp_err});
      check({tag, "_wc_a"},   {80'd0, if_a.WordCount}, {80'd0, exp_wc});
      check({tag, "_wc_b"},   {80'd0, if_b.WordCount}, {80'd0, exp_wc});
      check({tag, "_hold"},   {94'd0, if_a.CpuHold, if_b.CpuHold}, 96'd0);
      check({tag, "_ready"},  {94'd0, if_a.ByteReady, if_b.ByteReady}, 96'd0);
      check({tag, "_wr_left"}, 96'(exp_a_q.size() + exp_b_q.size()), 96'd0);
      exp_a_q.delete();
      exp_b_q.delete();
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_ctl_a"}, {91'd0, if_a.ByteReady, if_a.WrEn, if_a.CpuHold, if_a.Done, if_a.Error}, 96'd0);
      check({tag, "_ctl_b"}, {91'd0, if_b.ByteReady, if_b.WrEn, if_b.CpuHold, if_b.Done, if_b.Error}, 96'd0);
      check({tag, "_wc"},    {64'd0, if_a.WordCount, if_b.WordCount}, 96'd0);
      check({tag, "_wr_a"},  {if_a.WrAddr, if_a.WrData}, 96'd0);
      check({tag, "_wr_b"},  {if_b.WrAddr, if_b.WrData}, 96'd0);
   endtask

   task automatic set_good(input logic [7:0] last);
      stream_q = '{8'h02, 8'h00, 8'hE9, 8'h03, 8'h40, 8'hF8, 8'hEA, 8'h83, 8'h40, 8'hF8, last};
   endtask

   task automatic run_load(input string tag, input int valid_pct, input int start_at);
      model();
      start_load();
      send(valid_pct, start_at, stream_q.size());
      finish_stream();
      wait_result(tag);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int n;
      logic [7:0] x, b;
      if_a.Start = 1'b0;
      if_a.ByteIn = 8'h00;
      if_a.ByteValid = 1'b0;
      #1;
      check_zero("reset");
      repeat (3) @(negedge CLK);
      Reset_L = 1'b1;

      set_good(8'h83);
      run_load("good", 100, -1);

      set_good(8'h84);
      run_load("bad_csum", 100, -1);

      stream_q = '{8'h00, 8'h00};
      run_load("len_zero", 100, -1);

      stream_q = '{8'h29, 8'h00};
      run_load("len_big", 100, -1);

      stream_q = '{8'h28, 8'h01};
      run_load("len_hibyte", 100, -1);

      set_good(8'h83);
      run_load("gaps", 50, -1);

      // Abort right after the 4th data byte, while the first write is pending.
      set_good(8'h83);
      start_load();
      send(100, -1, 6);
      #1;
      Reset_L = 1'b0;
      lat_pending = 1'b0;
      #1;
      check_zero("midreset");
      @(negedge CLK);
      if_a.ByteValid = 1'b0;
      repeat (3) @(negedge CLK);
      check_zero("midreset_hold");
      Reset_L = 1'b1;
      run_load("after_reset", 100, -1);

      set_good(8'h83);
      run_load("start_in_data", 100, 4);

      for (int t = 0; t < 8; t++) begin
         n = $urandom_range(1, 6);
         x = 8'h00;
         stream_q.delete();
         stream_q.push_back(8'(n));
         stream_q.push_back(8'h00);
         for (int k = 0; k < 4*n; k++) begin
            b = 8'($urandom_range(255));
            x = x ^ b;
            stream_q.push_back(b);
         end
         if ($urandom_range(3) == 0) x = x ^ 8'(1 << $urandom_range(7));
         stream_q.push_back(x);
         run_load($sformatf("rand%0d", t), 60, -1);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
